rv32i_exec_datapath: RTL and testbench
======================================

# rv32i_exec_datapath

Combinational RV32I decode/execute/ALU datapath with its 32×32 integer register file, used inside the single-cycle core. Each cycle it takes the fetched instruction and current PC and produces:
- the next-PC redirect;
- the data-memory request;
- the register write-back, committed on the rising clock edge.

Fetch, PC register and data memory live outside this block.

## Interface
- No parameters (XLEN fixed at 32).
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock; register-file writes occur on its rising edge.
- rstn_i  in  1  asynchronous active-low reset; clears all 32 registers.
- instr_i  in  32  current instruction.
- pc_i  in  32  address of instr_i.
- load_rdata_i  in  32  word returned by data memory for mem_addr_o, available in the same cycle.
- jump_o  out  1  taken-branch or jump; next PC = jump_pc_o, else pc_i+4 (sequencing is external).
- jump_pc_o  out  32  redirect target; 0 when jump_o=0.
- mem_we_o  out  1  store enable.
- mem_addr_o  out  32  load/store effective address (rs1+imm); 0 when the instruction is neither a load nor a store.
- mem_wdata_o  out  32  rs2 value.
- mem_size_o  out  3  funct3 of the load/store (000 B, 001 H, 010 W, 100 BU, 101 HU).
- rd_we_o  out  1  register write-back enable; 0 when rd=0.
- rd_addr_o  out  5  instr[11:7] when rd_we_o=1, else 0.
- rd_wdata_o  out  32  write-back data; 0 when no write-back.
- alu_out_o  out  32  raw ALU result.

## Operation
- **Decode**
  - rs1/rs2 are read combinationally from instr[19:15]/[24:20]; x0 always reads 0.
  - Immediates are the standard I/S/B/U/J forms, sign-extended.
  - shamt = instr[24:20].
- **Execute (control)**
  - Selects ALU operands and a 5-bit ALU op: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, and PASS_B.
  - Shifts use the low 5 bits only: shamt for immediate shifts, rs2[4:0] for register shifts.
- **Per-opcode behaviour**
  - OP (0110011): rs1 op rs2 -> rd. SUB/SRA are selected by instr[30].
  - OP-IMM (0010011): rs1 op imm -> rd. SRAI is selected by instr[30].
  - LUI: PASS_B(U-imm) -> rd.
  - AUIPC: pc+U-imm -> rd.
  - JAL: ALU = pc+J-imm; jump_o=1; rd = pc+4.
  - JALR: ALU = (rs1+I-imm) with bit0 cleared; jump_o=1; rd = pc+4.
  - BRANCH (BEQ/BNE/BLT/BGE/BLTU/BGEU): ALU = pc+B-imm; jump_o = comparison of rs1 vs rs2 (signed or unsigned per funct3); no rd write.
  - LOAD: ALU = rs1+I-imm.
    - rd gets load_rdata_i extended per funct3.
    - LB/LBU take bits [7:0], sign- or zero-extended from bit 7.
    - LH/LHU take bits [15:0], sign- or zero-extended from bit 15.
    - LW takes the whole word.
    - Any other funct3 writes 0.
  - STORE: ALU = rs1+S-imm; mem_we_o=1; no rd write.
  - FENCE, SYSTEM and any unrecognised opcode: no write, no store, no jump.
- **Signed/width rules**
  - SLT/BLT/BGE compare signed; SLTU/BLTU/BGEU compare unsigned.
  - All additions wrap modulo 2^32.
  - SRA replicates bit 31.

## Timing
- All outputs are purely combinational from instr_i, pc_i, load_rdata_i and register contents, with no latency.
- Register write: on the rising edge of clk_i when rd_we_o=1, reg[rd] <= rd_wdata_o. The new value is visible to reads after that edge; there is no internal bypass.
- Reset:
  - rstn_i=0 asynchronously clears all registers to 0 and blocks writes while low.
  - Outputs are then combinational functions of the inputs with all registers reading 0.
  - A reset asserted in mid-cycle discards any pending write.
- Writes to x0 never happen, and x0 always reads 0.

## Test plan
- **Reset then ADDI:** rstn_i=0, then 1; instr ADDI x1,x0,5.
  - Required: rd_we_o=1, rd_addr_o=1, rd_wdata_o=5.
  - After the edge, ADD x2,x1,x1 gives rd_wdata_o=10.
- **Signed shift and compares:** x1=0x8000_0000.
  - SRAI x3,x1,4 -> 0xF800_0000.
  - SRLI -> 0x0800_0000.
  - SLT x4,x1,x0 -> 1; SLTU -> 0.
- **Branch and JALR redirect:**
  - pc=0x8000_0010, BEQ x1,x1,-8 -> jump_o=1, jump_pc_o=0x8000_0008.
  - BNE with equal operands -> jump_o=0.
  - JALR x5,x1,3 with x1=0x100 -> jump_pc_o=0x102, rd_wdata_o=0x8000_0014.
- **Loads:** load_rdata_i=0x0000_8F80, address x1+4=0x104.
  - LB -> 0xFFFF_FF80.
  - LBU -> 0x80.
  - LH -> 0xFFFF_8F80.
  - LHU -> 0x8F80.
  - mem_addr_o=0x104.
- **Store, x0 write, illegal opcode:**
  - SW x2,8(x1) -> mem_we_o=1, mem_addr_o=x1+8, mem_wdata_o=x2, rd_we_o=0.
  - ADDI x0,x0,7 -> rd_we_o=0, and x0 still reads 0.
  - Opcode 0x7F -> all enables 0.

Source files
------------

// File: rtl/rv32i_exec_datapath.sv
// RV32I decode/execute/ALU datapath with its 32x32 register file.
// Purely combinational apart from the register-file write port.
module rv32i_exec_datapath (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] load_rdata_i,
   output logic        jump_o,
   output logic [31:0] jump_pc_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [2:0]  mem_size_o,
   output logic        rd_we_o,
   output logic [4:0]  rd_addr_o,
   output logic [31:0] rd_wdata_o,
   output logic [31:0] alu_out_o
);

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
   } alu_op_e;

   logic [31:0] regs [32];

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [4:0]  rd, rs1a, rs2a;
   logic [31:0] rs1, rs2;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = instr_i[6:0];
   assign rd     = instr_i[11:7];
   assign f3     = instr_i[14:12];
   assign rs1a   = instr_i[19:15];
   assign rs2a   = instr_i[24:20];
   assign rs1    = (rs1a == 5'd0) ? 32'd0 : regs[rs1a];
   assign rs2    = (rs2a == 5'd0) ? 32'd0 : regs[rs2a];

   assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                   instr_i[30:25], instr_i[11:8], 1'b0};
   assign imm_u = {instr_i[31:12], 12'd0};
   assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                   instr_i[20], instr_i[30:21], 1'b0};

   logic is_op, is_opi, is_lui, is_aui, is_jal, is_jalr;
   logic is_br, is_ld, is_st;

   assign is_op   = (opcode == 7'b0110011);
   assign is_opi  = (opcode == 7'b0010011);
   assign is_lui  = (opcode == 7'b0110111);
   assign is_aui  = (opcode == 7'b0010111);
   assign is_jal  = (opcode == 7'b1101111);
   assign is_jalr = (opcode == 7'b1100111);
   assign is_br   = (opcode == 7'b1100011);
   assign is_ld   = (opcode == 7'b0000011);
   assign is_st   = (opcode == 7'b0100011);

   function automatic alu_op_e f3_op(input logic [2:0] f, input logic alt);
      alu_op_e o;
      unique case (f)
         3'b000:  o = alt ? ALU_SUB : ALU_ADD;
         3'b001:  o = ALU_SLL;
         3'b010:  o = ALU_SLT;
         3'b011:  o = ALU_SLTU;
         3'b100:  o = ALU_XOR;
         3'b101:  o = alt ? ALU_SRA : ALU_SRL;
         3'b110:  o = ALU_OR;
         default: o = ALU_AND;
      endcase
      return o;
   endfunction

   logic [31:0] op_a, op_b;
   alu_op_e     alu_op;

   // Operand and ALU-op selection per opcode class
   always_comb begin
      op_a   = rs1;
      op_b   = rs2;
      alu_op = ALU_ADD;
      unique case (1'b1)
         is_op: alu_op = f3_op(f3, instr_i[30]);
         is_opi: begin
            op_b   = imm_i;
            alu_op = f3_op(f3, instr_i[30] & (f3 == 3'b101));
         end
         is_lui: begin
            op_b   = imm_u;
            alu_op = ALU_PASS_B;
         end
         is_aui: begin
            op_a = pc_i;
            op_b = imm_u;
         end
         is_jal: begin
            op_a = pc_i;
            op_b = imm_j;
         end
         is_jalr: op_b = imm_i;
         is_br: begin
            op_a = pc_i;
            op_b = imm_b;
         end
         is_ld: op_b = imm_i;
         is_st: op_b = imm_s;
         default: ;
      endcase
   end

   logic [31:0] alu_res;

   // ALU; shifts use only the low five bits of operand B
   always_comb begin
      alu_res = 32'd0;
      unique case (alu_op)
         ALU_ADD:    alu_res = op_a + op_b;
         ALU_SUB:    alu_res = op_a - op_b;
         ALU_SLL:    alu_res = op_a << op_b[4:0];
         ALU_SLT:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
         ALU_SLTU:   alu_res = {31'd0, op_a < op_b};
         ALU_XOR:    alu_res = op_a ^ op_b;
         ALU_SRL:    alu_res = op_a >> op_b[4:0];
         ALU_SRA:    alu_res = 32'($signed(op_a) >>> op_b[4:0]);
         ALU_OR:     alu_res = op_a | op_b;
         ALU_AND:    alu_res = op_a & op_b;
         ALU_PASS_B: alu_res = op_b;
         default:    alu_res = 32'd0;
      endcase
   end

   assign alu_out_o = is_jalr ? {alu_res[31:1], 1'b0} : alu_res;

   logic br_take;

   // Branch condition from register operands
   always_comb begin
      br_take = 1'b0;
      unique case (f3)
         3'b000:  br_take = (rs1 == rs2);
         3'b001:  br_take = (rs1 != rs2);
         3'b100:  br_take = ($signed(rs1) < $signed(rs2));
         3'b101:  br_take = !($signed(rs1) < $signed(rs2));
         3'b110:  br_take = (rs1 < rs2);
         3'b111:  br_take = !(rs1 < rs2);
         default: br_take = 1'b0;
      endcase
   end

   assign jump_o      = is_jal | is_jalr | (is_br & br_take);
   assign jump_pc_o   = jump_o ? alu_out_o : 32'd0;
   assign mem_we_o    = is_st;
   assign mem_addr_o  = (is_ld | is_st) ? alu_out_o : 32'd0;
   assign mem_wdata_o = rs2;
   assign mem_size_o  = (is_ld | is_st) ? f3 : 3'd0;

   logic wb_cls;
   logic [31:0] ld_val;

   assign wb_cls  = is_op | is_opi | is_lui | is_aui
                  | is_jal | is_jalr | is_ld;
   assign rd_we_o   = wb_cls & (rd != 5'd0);
   assign rd_addr_o = rd_we_o ? rd : 5'd0;

   // Load data extension by access size
   always_comb begin
      ld_val = 32'd0;
      unique case (f3)
         3'b000:  ld_val = {{24{load_rdata_i[7]}}, load_rdata_i[7:0]};
         3'b001:  ld_val = {{16{load_rdata_i[15]}}, load_rdata_i[15:0]};
         3'b010:  ld_val = load_rdata_i;
         3'b100:  ld_val = {24'd0, load_rdata_i[7:0]};
         3'b101:  ld_val = {16'd0, load_rdata_i[15:0]};
         default: ld_val = 32'd0;
      endcase
   end

   // Write-back data mux
   always_comb begin
      rd_wdata_o = 32'd0;
      if (rd_we_o) begin
         if (is_jal | is_jalr) rd_wdata_o = pc_i + 32'd4;
         else if (is_ld)       rd_wdata_o = ld_val;
         else                  rd_wdata_o = alu_out_o;
      end
   end

   // Register file write port; reset clears every entry
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else if (rd_we_o) begin
         regs[rd_addr_o] <= rd_wdata_o;
      end
   end

endmodule

// File: tb/tb_rv32i_exec_datapath.sv
// Scoreboard bench for rv32i_exec_datapath.
// Expected outputs are queued on drive and compared on sample.
module tb_rv32i_exec_datapath;

   logic        clk = 1'b0;
   logic        rstn_i = 1'b0;
   logic [31:0] instr_i = 32'd0;
   logic [31:0] pc_i = 32'd0;
   logic [31:0] load_rdata_i = 32'd0;
   logic        jump_o, mem_we_o, rd_we_o;
   logic [31:0] jump_pc_o, mem_addr_o, mem_wdata_o;
   logic [31:0] rd_wdata_o, alu_out_o;
   logic [2:0]  mem_size_o;
   logic [4:0]  rd_addr_o;

   always #5 clk = ~clk;

   rv32i_exec_datapath dut (
      .clk_i(clk), .rstn_i(rstn_i), .instr_i(instr_i),
      .pc_i(pc_i), .load_rdata_i(load_rdata_i),
      .jump_o(jump_o), .jump_pc_o(jump_pc_o),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
      .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o),
      .rd_wdata_o(rd_wdata_o), .alu_out_o(alu_out_o)
   );

   typedef struct packed {
      logic        j;
      logic [31:0] jpc;
      logic        we;
      logic [31:0] maddr;
      logic [31:0] wdata;
      logic [2:0]  size;
      logic        rwe;
      logic [4:0]  rda;
      logic [31:0] rwd;
      logic [31:0] alu;
   } obs_t;

   typedef struct {
      string name;
      obs_t  v;
      bit    care;
   } ent_t;

   obs_t got_w;
   assign got_w = {jump_o, jump_pc_o, mem_we_o, mem_addr_o, mem_wdata_o,
                   mem_size_o, rd_we_o, rd_addr_o, rd_wdata_o, alu_out_o};

   ent_t exp_q[$];
   obs_t got_q[$];
   logic [31:0] mdl [32];
   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] enc_i(input logic [31:0] imm,
      input logic [4:0] rs1, input logic [2:0] f3,
      input logic [4:0] rd, input logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7,
      input logic [4:0] rs2, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_s(input logic [31:0] imm,
      input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input logic [31:0] imm,
      input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_j(input logic [31:0] imm,
      input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
   endfunction

   function automatic obs_t wbk(input logic [4:0] a,
      input logic [31:0] d, input logic [31:0] alu);
      obs_t o = '0;
      o.rwe = 1'b1;
      o.rda = a;
      o.rwd = d;
      o.alu = alu;
      return o;
   endfunction

   function automatic obs_t nowb(input logic [31:0] alu);
      obs_t o = '0;
      o.alu = alu;
      return o;
   endfunction

   // drive one instruction, queue its expectation, sample DUT
   task automatic issue(input string n, input logic [31:0] ins,
      input logic [31:0] pc, input logic [31:0] ld, input logic rst,
      input obs_t e, input bit care = 1'b1);
      ent_t en;
      @(negedge clk);
      rstn_i = rst;
      instr_i = ins;
      pc_i = pc;
      load_rdata_i = ld;
      e.wdata = mdl[ins[24:20]];
      en.name = n;
      en.v = e;
      en.care = care;
      exp_q.push_back(en);
      #2;
      got_q.push_back(got_w);
      if (rst && e.rwe) mdl[e.rda] = e.rwd;
   endtask

   task automatic test_reset();
      ent_t en;
      obs_t g;
      issue("rst_addi", enc_i(5, 0, 0, 1, 7'h13), 0, 0, 0, wbk(1, 5, 5));
      issue("rst_nowr", enc_r(0, 1, 1, 0, 3), 0, 0, 0, wbk(3, 0, 0));
      issue("addi_x1", enc_i(5, 0, 0, 1, 7'h13), 0, 0, 1, wbk(1, 5, 5));
      issue("add_x2", enc_r(0, 1, 1, 0, 2), 0, 0, 1, wbk(2, 10, 10));
      while (exp_q.size() > 0) begin
         en = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (!en.care) g.alu = en.v.alu;
         if (g !== en.v) begin
            errors++;
            $display("FAIL %s: got %h want %h", en.name, g, en.v);
         end
      end
   endtask

   task automatic test_shift_compare();
      ent_t en;
      obs_t g;
      issue("lui", {20'h80000, 5'd1, 7'h37}, 0, 0, 1,
            wbk(1, 32'h8000_0000, 32'h8000_0000));
      issue("srai", enc_i(32'h404, 1, 3'b101, 3, 7'h13), 0, 0, 1,
            wbk(3, 32'hF800_0000, 32'hF800_0000));
      issue("srli", enc_i(4, 1, 3'b101, 3, 7'h13), 0, 0, 1,
            wbk(3, 32'h0800_0000, 32'h0800_0000));
      issue("slt", enc_r(0, 0, 1, 3'b010, 4), 0, 0, 1, wbk(4, 1, 1));
      issue("sltu", enc_r(0, 0, 1, 3'b011, 4), 0, 0, 1, wbk(4, 0, 0));
      issue("sub", enc_r(7'h20, 2, 0, 3'b000, 5), 0, 0, 1,
            wbk(5, 32'hFFFF_FFF6, 32'hFFFF_FFF6));
      issue("sra", enc_r(7'h20, 2, 1, 3'b101, 6), 0, 0, 1,
            wbk(6, 32'hFFE0_0000, 32'hFFE0_0000));
      while (exp_q.size() > 0) begin
         en = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (!en.care) g.alu = en.v.alu;
         if (g !== en.v) begin
            errors++;
            $display("FAIL %s: got %h want %h", en.name, g, en.v);
         end
      end
   endtask

   task automatic test_branch_jump();
      ent_t en;
      obs_t g, e;
      logic [31:0] pc = 32'h8000_0010;
      e = nowb(32'h8000_0008); e.j = 1; e.jpc = 32'h8000_0008;
      issue("beq", enc_b(-32'sd8, 1, 1, 3'b000), pc, 0, 1, e);
      issue("bne", enc_b(-32'sd8, 1, 1, 3'b001), pc, 0, 1,
            nowb(32'h8000_0008));
      e = nowb(32'h8000_0020); e.j = 1; e.jpc = 32'h8000_0020;
      issue("blt", enc_b(16, 0, 1, 3'b100), pc, 0, 1, e);
      issue("bltu", enc_b(16, 0, 1, 3'b110), pc, 0, 1,
            nowb(32'h8000_0020));
      issue("addi_100", enc_i(32'h100, 0, 0, 1, 7'h13), pc, 0, 1,
            wbk(1, 32'h100, 32'h100));
      e = wbk(5, 32'h8000_0014, 32'h102); e.j = 1; e.jpc = 32'h102;
      issue("jalr", enc_i(3, 1, 0, 5, 7'h67), pc, 0, 1, e);
      e = wbk(7, 32'h8000_0014, 32'h8000_0030);
      e.j = 1; e.jpc = 32'h8000_0030;
      issue("jal", enc_j(32'h20, 7), pc, 0, 1, e);
      while (exp_q.size() > 0) begin
         en = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (!en.care) g.alu = en.v.alu;
         if (g !== en.v) begin
            errors++;
            $display("FAIL %s: got %h want %h", en.name, g, en.v);
         end
      end
   endtask

   task automatic test_loads();
      ent_t en;
      obs_t g, e;
      logic [31:0] rdat = 32'h0000_8F80;
      logic [31:0] want [8];
      want[0] = 32'hFFFF_FF80; want[1] = 32'hFFFF_8F80;
      want[2] = 32'h0000_8F80; want[3] = 32'h0;
      want[4] = 32'h0000_0080; want[5] = 32'h0000_8F80;
      for (int f = 0; f < 6; f++) begin
         e = wbk(8, want[f], 32'h104);
         e.maddr = 32'h104;
         e.size = 3'(f);
         issue($sformatf("load_f3_%0d", f),
               enc_i(4, 1, 3'(f), 8, 7'h03), 0, rdat, 1, e);
      end
      while (exp_q.size() > 0) begin
         en = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (!en.care) g.alu = en.v.alu;
         if (g !== en.v) begin
            errors++;
            $display("FAIL %s: got %h want %h", en.name, g, en.v);
         end
      end
   endtask

   task automatic test_store_x0_illegal();
      ent_t en;
      obs_t g, e;
      e = nowb(32'h108); e.we = 1; e.maddr = 32'h108; e.size = 3'b010;
      issue("sw", enc_s(8, 2, 1, 3'b010), 0, 0, 1, e);
      issue("addi_x0", enc_i(7, 0, 0, 0, 7'h13), 0, 0, 1, nowb(7));
      issue("x0_read", enc_r(0, 0, 0, 0, 9), 0, 0, 1, wbk(9, 0, 0));
      issue("illegal", 32'hFFFF_FFFF, 32'h40, 32'h1234, 1, nowb(0), 1'b0);
      while (exp_q.size() > 0) begin
         en = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (!en.care) g.alu = en.v.alu;
         if (g !== en.v) begin
            errors++;
            $display("FAIL %s: got %h want %h", en.name, g, en.v);
         end
      end
   endtask

   task automatic test_mid_reset();
      ent_t en;
      obs_t g;
      issue("addi_x7", enc_i(9, 0, 0, 7, 7'h13), 0, 0, 1, wbk(7, 9, 9));
      #1 rstn_i = 1'b0;
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      issue("post_x7", enc_r(0, 7, 7, 0, 8), 0, 0, 1, wbk(8, 0, 0));
      issue("post_x1", enc_r(0, 0, 1, 0, 9), 0, 0, 1, wbk(9, 0, 0));
      while (exp_q.size() > 0) begin
         en = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (!en.care) g.alu = en.v.alu;
         if (g !== en.v) begin
            errors++;
            $display("FAIL %s: got %h want %h", en.name, g, en.v);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      test_reset();
      test_shift_compare();
      test_branch_jump();
      test_loads();
      test_store_x0_illegal();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
